// File: rtl/cmp_pkg.sv
// Shared types for the compare-resource arbiter: funct3 op codes,
// pipeline stage bundles and the reserved-op decode helper.
package cmp_pkg;

  typedef enum logic [2:0] {
    OP_EQ  = 3'b000,
    OP_NE  = 3'b001,
    OP_LT  = 3'b100,
    OP_GE  = 3'b101,
    OP_LTU = 3'b110,
    OP_GEU = 3'b111
  } cmp_op_e;

  // Widest id needed for up to 8 requesters.
  localparam int MAX_IDW = 3;

  // Codes 010 and 011 are reserved: op[2:1] == 2'b01.
  localparam logic [2:0] RSV_MASK = 3'b110;
  localparam logic [2:0] RSV_CODE = 3'b010;

  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] id;
    logic [31:0]        a;
    logic [31:0]        b;
    logic [2:0]         op;
  } s1_t;

  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] id;
    logic               result;
    logic               err;
  } s2_t;

  function automatic logic is_rsv(input logic [2:0] op);
    return (op & RSV_MASK) == RSV_CODE;
  endfunction

endpackage

// File: rtl/comparator_32bit.sv
// Signed 32-bit less-than comparator.
// Ports: a, b operands; lt = (a < b) signed.
module comparator_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        lt
);

  assign lt = $signed(a) < $signed(b);

endmodule

// File: rtl/rr_arb.sv
// Round-robin pick: first set req bit at or after ptr, wrapping.
// Ports: req, ptr, en in; one-hot gnt, binary idx, any out.
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + i) % N);
      end
    end
    gnt[idx] = found & en;
  end

  assign any = found & en;

endmodule

// File: rtl/cmp_arbiter.sv
// Shared compare unit: round-robin grant, two-stage pipe, tagged rsp.
// Ports: i_req_* per requester, o_req_ready grant, o_rsp_* response.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic [NREQ-1:0]            i_req_valid,
  output logic [NREQ-1:0]            o_req_ready,
  input  logic [NREQ-1:0][31:0]      i_req_a,
  input  logic [NREQ-1:0][31:0]      i_req_b,
  input  logic [NREQ-1:0][2:0]       i_req_op,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [IDW-1:0]             o_rsp_id,
  output logic                       o_rsp_result,
  output logic                       o_rsp_err
);

  s1_t s1_q;
  s2_t s2_q;

  logic            adv1;
  logic            adv2;
  logic            gnt_en;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  ptr_q;
  logic [NREQ-1:0] gnt;

  assign adv2 = !s2_q.valid | i_rsp_ready;
  assign adv1 = !s1_q.valid | adv2;
  // Ready stays low while reset is held.
  assign gnt_en = adv1 & !i_flush & i_rst_n;

  rr_arb #(
    .N  (NREQ),
    .IW (IDW)
  ) u_arb (
    .req (i_req_valid),
    .ptr (ptr_q),
    .en  (gnt_en),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign o_req_ready = gnt;

  logic        uns;
  logic        lt;
  logic        eq;
  logic        rsv;
  logic        res;
  logic [31:0] ca;
  logic [31:0] cb;

  // Flipping the sign bit maps unsigned order onto signed order.
  assign uns = (s1_q.op == OP_LTU) | (s1_q.op == OP_GEU);
  assign ca  = {s1_q.a[31] ^ uns, s1_q.a[30:0]};
  assign cb  = {s1_q.b[31] ^ uns, s1_q.b[30:0]};

  comparator_32bit u_cmp (
    .a  (ca),
    .b  (cb),
    .lt (lt)
  );

  assign eq  = s1_q.a == s1_q.b;
  assign rsv = is_rsv(s1_q.op);
  // op[2] picks lt vs eq, op[0] inverts.
  assign res = !rsv & ((s1_q.op[2] ? lt : eq) ^ s1_q.op[0]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      ptr_q <= (gnt_idx == IDW'(NREQ - 1)) ? '0
             : gnt_idx + IDW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q <= '0;
    end else if (i_flush) begin
      s1_q.valid <= 1'b0;
    end else if (adv1) begin
      s1_q.valid <= gnt_any;
      if (gnt_any) begin
        s1_q.id <= MAX_IDW'(gnt_idx);
        s1_q.a  <= i_req_a[gnt_idx];
        s1_q.b  <= i_req_b[gnt_idx];
        s1_q.op <= i_req_op[gnt_idx];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_q <= '0;
    end else if (i_flush) begin
      s2_q.valid <= 1'b0;
    end else if (adv2) begin
      s2_q.valid <= s1_q.valid;
      if (s1_q.valid) begin
        s2_q.id     <= s1_q.id;
        s2_q.result <= res;
        s2_q.err    <= rsv;
      end
    end
  end

  assign o_rsp_valid  = s2_q.valid;
  assign o_rsp_id     = IDW'(s2_q.id);
  assign o_rsp_result = s2_q.result;
  assign o_rsp_err    = s2_q.err;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Randomized + directed bench for cmp_arbiter against a
// latency/queue reference model.
module tb_cmp_arbiter;
  import cmp_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic rsp_ready = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N-1:0][31:0] req_a = '0;
  logic [N-1:0][31:0] req_b = '0;
  logic [N-1:0][2:0]  req_op = '0;
  logic rsp_valid;
  logic [IW-1:0] rsp_id;
  logic rsp_result;
  logic rsp_err;

  always #5 clk = ~clk;

  cmp_arbiter #(
    .NREQ (N),
    .IDW  (IW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .i_req_op     (req_op),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_id     (rsp_id),
    .o_rsp_result (rsp_result),
    .o_rsp_err    (rsp_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int id;
    bit res;
    bit err;
    bit vis;
  } ent_t;

  ent_t q[$];
  int   ptr_m = 0;
  bit   pend[N];
  int   last_gnt = -1;

  function automatic void ref_cmp(input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic [2:0] op,
                                  output bit r,
                                  output bit e);
    r = 0;
    e = 0;
    case (op)
      3'b000: r = (a == b);
      3'b001: r = (a != b);
      3'b100: r = ($signed(a) < $signed(b));
      3'b101: r = ($signed(a) >= $signed(b));
      3'b110: r = (a < b);
      3'b111: r = (a >= b);
      default: e = 1;
    endcase
  endfunction

  task automatic new_req(input int i);
    logic [31:0] a;
    a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
    pend[i]   = 1;
    req_a[i]  = a;
    req_b[i]  = ($urandom_range(0, 3) == 0) ? a : $urandom;
    req_op[i] = 3'($urandom);
  endtask

  task automatic set_req(input int i, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op);
    pend[i]   = 1;
    req_a[i]  = a;
    req_b[i]  = b;
    req_op[i] = op;
  endtask

  task automatic clr_all();
    for (int i = 0; i < N; i++) pend[i] = 0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < N; i++) if (!pend[i]) new_req(i);
  endtask

  // One clock cycle: drive, check against model, step model.
  task automatic cycle();
    int w;
    bit vis;
    bit cons;
    logic [N-1:0] exp_rdy;
    ent_t e;
    for (int i = 0; i < N; i++) req_valid[i] = pend[i];
    #1;
    vis  = (q.size() > 0) && q[0].vis;
    cons = vis && rsp_ready;
    check("rsp_valid", rsp_valid, vis);
    if (vis) begin
      check("rsp_id", rsp_id, q[0].id);
      check("rsp_result", rsp_result, q[0].res);
      check("rsp_err", rsp_err, q[0].err);
    end
    w = -1;
    if (!flush && (q.size() < 2 || cons)) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req_valid[(ptr_m + k) % N]) w = (ptr_m + k) % N;
      end
    end
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
      w = -1;
    end else begin
      if (cons) void'(q.pop_front());
      foreach (q[k]) q[k].vis = 1;
      if (w >= 0) begin
        ref_cmp(req_a[w], req_b[w], req_op[w], e.res, e.err);
        e.id  = w;
        e.vis = 0;
        q.push_back(e);
        ptr_m   = (w + 1) % N;
        pend[w] = 0;
      end
    end
    last_gnt = w;
  endtask

  task automatic expect_rsp(input string tag, input int id,
                            input bit r, input bit e);
    check({tag, "_v"}, rsp_valid, 1'b1);
    check({tag, "_id"}, rsp_id, id);
    check({tag, "_res"}, rsp_result, r);
    check({tag, "_err"}, rsp_err, e);
  endtask

  task automatic issue0(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] op,
                        input bit r, input bit e);
    set_req(0, a, b, op);
    cycle();
    check({tag, "_gnt"}, last_gnt, 0);
    cycle();
    expect_rsp(tag, 0, r, e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    q.delete();
    ptr_m = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int acc;
  int id_hold;
  int g1;
  int g2;

  initial begin
    clr_all();
    @(posedge clk);
    #1;
    fill_all();
    for (int i = 0; i < N; i++) req_valid[i] = pend[i];
    #1;
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_id", rsp_id, 0);
    check("rst_result", rsp_result, 1'b0);
    check("rst_err", rsp_err, 1'b0);
    check("rst_ready", req_ready, '0);
    clr_all();
    rst_n = 1'b1;

    // Directed compares from requester 0.
    issue0("lt", 32'hFFFF_FFFF, 32'h1, OP_LT, 1, 0);
    issue0("ltu", 32'hFFFF_FFFF, 32'h1, OP_LTU, 0, 0);
    issue0("geu", 32'hFFFF_FFFF, 32'h1, OP_GEU, 1, 0);
    issue0("eq", 32'h1234_5678, 32'h1234_5678, OP_EQ, 1, 0);
    issue0("ne", 32'h1234_5678, 32'h1234_5678, OP_NE, 0, 0);
    issue0("rsv", 32'h1234_5678, 32'h1234_5678, 3'b010, 0, 1);
    cycle();

    // Round-robin fairness with all requesters busy.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      fill_all();
      cycle();
      check("rr_gnt", last_gnt, k % N);
      if (k >= 1) begin
        check("rr_rv", rsp_valid, 1'b1);
        check("rr_id", rsp_id, (k - 1) % N);
      end
    end

    // Backpressure: two accepted, id stable, then drain.
    clr_all();
    for (int k = 0; k < 3; k++) cycle();
    rsp_ready = 1'b0;
    acc = 0;
    id_hold = 0;
    for (int k = 0; k < 5; k++) begin
      fill_all();
      cycle();
      if (last_gnt >= 0) acc++;
      if (k == 1) id_hold = rsp_id;
      if (k >= 2) check("bp_id_hold", rsp_id, id_hold);
    end
    check("bp_accepts", acc, 2);
    clr_all();
    rsp_ready = 1'b1;
    cycle();
    check("bp_drain1", rsp_valid, 1'b1);
    cycle();
    check("bp_drain2", rsp_valid, 1'b0);

    // Flush with two in flight.
    rsp_ready = 1'b0;
    fill_all();
    cycle();
    g1 = last_gnt;
    cycle();
    g2 = last_gnt;
    check("fl_two", (g1 >= 0) && (g2 >= 0), 1'b1);
    flush = 1'b1;
    rsp_ready = 1'b1;
    cycle();
    flush = 1'b0;
    clr_all();
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("fl_norsp", rsp_valid, 1'b0);
    end
    fill_all();
    cycle();
    check("fl_ptr", last_gnt, (g2 + 1) % N);

    // Random traffic with backpressure and occasional flush.
    for (int k = 0; k < 1500; k++) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 9) < 4) new_req(i);
      end
      cycle();
    end
    flush = 1'b0;
    rsp_ready = 1'b1;

    // Async reset while s2 holds a response.
    clr_all();
    for (int k = 0; k < 3; k++) cycle();
    new_req(2);
    cycle();
    cycle();
    check("ar_s2", rsp_valid, 1'b1);
    fill_all();
    rst_n = 1'b0;
    q.delete();
    ptr_m = 0;
    #1;
    check("ar_valid", rsp_valid, 1'b0);
    check("ar_ready", req_ready, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    check("ar_gnt0", last_gnt, 0);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
